hazard_sched: RTL
=================

// Module: hazard_sched
// PURPOSE
//   Pipeline hazard scheduler. Sits beside the decode controller and sequences the
//   IF/ID/EX/MEM/WB pipe. It tracks destination registers of in-flight instructions
//   (EX, MEM and WB slots) and detects RAW hazards against the instruction in ID.
//   It issues stall, bubble, flush and forwarding-select controls, and counts lost cycles.
// PARAMETERS
//   FORWARDING    1   1: forward from MEM/WB and stall only on load-use; 0: stall on any RAW match
//   FLUSH_CYCLES  2   cycles ifid_flush stays high per redirect, redirect cycle included (range 1..7)
//   CNT_W         16  width of the saturating performance counters
// PORTS
//   clock         in   1      rising-edge clock
//   reset_n       in   1      asynchronous, active-low reset
//   id_valid      in   1      ID holds a real instruction; 0 = NOP/bubble
//   id_rs1        in   5      ID source register 1
//   id_rs2        in   5      ID source register 2
//   id_use_rs1    in   1      ID instruction reads rs1
//   id_use_rs2    in   1      ID instruction reads rs2
//   id_rd         in   5      ID destination register
//   id_reg_en     in   1      ID instruction writes rd (REG_EN from decode)
//   id_is_load    in   1      ID instruction is a load (MEMTOREG from decode)
//   ex_redirect   in   1      EX resolved a taken branch/JAL/JALR this cycle
//   pc_stall      out  1      hold PC (combinational)
//   ifid_stall    out  1      hold IF/ID register (combinational)
//   idex_bubble   out  1      load NOP into ID/EX instead of ID (combinational)
//   ifid_flush    out  1      squash IF/ID contents (combinational)
//   fwd_a         out  2      EX operand A source: 00 regfile, 01 EX/MEM result, 10 MEM/WB result (registered)
//   fwd_b         out  2      EX operand B source, same encoding (registered)
//   state         out  2      00 RUN, 01 STALL, 10 FLUSH (registered)
//   stall_cnt     out  CNT_W  stall cycles since reset, saturating
//   flush_cnt     out  CNT_W  flush cycles since reset, saturating
// BEHAVIOUR
// - Slot entry = {v, rd, ld}, held for EX, MEM and WB. Every edge: WB<=MEM, MEM<=EX,
//   EX<=ID entry, or an empty entry if idex_bubble or !id_valid. v = id_valid & id_reg_en & (id_rd!=0).
// - match(S, r) = S.v & S.rd==r & r!=0, checked per source only when its use bit is set.
//   Register x0 never hazards.
// - hazard: FORWARDING=1 -> match(EX) with EX.ld (load-use).
//           FORWARDING=0 -> match(EX) | match(MEM) | match(WB).
// - Priority: ex_redirect > hazard.
//   Redirect cycle: ifid_flush=1, idex_bubble=1, pc_stall=0, ifid_stall=0.
//   Hazard (no redirect, state != FLUSH): pc_stall=ifid_stall=idex_bubble=1.
// - FSM:
//   RUN -> STALL on hazard.
//   STALL -> RUN when hazard clears.
//   any state -> FLUSH on ex_redirect, fcnt <= FLUSH_CYCLES-1.
//   FLUSH: ifid_flush=idex_bubble=1 while fcnt!=0; decrement each cycle; -> RUN when fcnt==0.
//   Hazards are ignored during FLUSH.
//   FLUSH_CYCLES=1: redirect-cycle flush only, stays in RUN.
//   A redirect during FLUSH reloads fcnt.
// - Forwarding (FORWARDING=1 only; otherwise fwd_a/fwd_b stay 00). Registered when ID advances
//   into EX (no bubble):
//   fwd_a <= match(EX, rs1) ? 01 : match(MEM, rs1) ? 10 : 00; fwd_b likewise for rs2.
//   The newest producer wins. On a bubble, fwd_a/fwd_b <= 00.
// - Load-use latency: exactly 1 stall cycle, then the consumer gets fwd=10.
// - Counters: stall_cnt +1 per cycle with pc_stall=1 and no redirect.
//   flush_cnt +1 per cycle with ifid_flush=1. Both saturate at all-ones.
// - Reset (async, reset_n=0): all slots empty, state=RUN, fcnt=0, fwd_a=fwd_b=00,
//   counters=0. Combinational outputs are then 0 because no hazard is possible.
//   Reset mid-stall or mid-flush aborts it immediately.
// TESTING
// - Reset while in FLUSH with fcnt=1 -> state=00, all outputs 0, counters 0, on the next cycle too.
// - FWD=1: lw x5 then add x6,x5,x1 -> 1 cycle of pc_stall/idex_bubble; add enters EX with
//   fwd_a=10; stall_cnt=1.
// - FWD=1: add x5,... then sub x7,x5,x5 -> no stall; fwd_a=fwd_b=01. One instruction between
//   them -> fwd=10.
// - FWD=0: add x5 followed by consumer of x5 -> 3 stall cycles. The same pattern with rd=x0 -> 0 stalls.
// - ex_redirect with FLUSH_CYCLES=2 -> ifid_flush high 2 cycles, flush_cnt=2; a concurrent
//   load-use hazard is suppressed.
// - Redirect in the 2nd FLUSH cycle -> flush extends 2 more cycles. Force counter to max-1 and
//   stall 3 cycles -> count holds at all-ones.

Source files
------------

// File: rtl/hazard_sched_if.sv
// Handshake bundle between decode control and the hazard scheduler.
// Decode drives the ID view and redirect; the scheduler drives pipe controls.
interface hazard_sched_if #(
  parameter int unsigned CNT_W = 16
);
  logic             id_valid;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [4:0]       id_rd;
  logic             id_reg_en;
  logic             id_is_load;
  logic             ex_redirect;
  logic             pc_stall;
  logic             ifid_stall;
  logic             idex_bubble;
  logic             ifid_flush;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2,
    output id_use_rs1, id_use_rs2,
    output id_rd, id_reg_en, id_is_load,
    output ex_redirect,
    input  pc_stall, ifid_stall,
    input  idex_bubble, ifid_flush,
    input  fwd_a, fwd_b, state,
    input  stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2,
    input  id_use_rs1, id_use_rs2,
    input  id_rd, id_reg_en, id_is_load,
    input  ex_redirect,
    output pc_stall, ifid_stall,
    output idex_bubble, ifid_flush,
    output fwd_a, fwd_b, state,
    output stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_sched.sv
// Hazard scheduler: RAW detection over EX/MEM/WB slots, stall/flush
// sequencing, forwarding selects and saturating lost-cycle counters.
module hazard_sched #(
  parameter bit          FORWARDING   = 1'b1,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input logic           clock,
  input logic           reset_n,
  hazard_sched_if.slave hs
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    STALL = 2'b01,
    FLUSH = 2'b10
  } st_e;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
  } slot_t;

  localparam logic [2:0] FLOAD = 3'(FLUSH_CYCLES - 1);

  function automatic logic match(input slot_t s, input logic [4:0] r);
    return s.v && (s.rd == r) && (r != 5'd0);
  endfunction

  slot_t            ex_q, mem_q, wb_q, ex_d;
  logic             ex_ld_q, ex_ld_d;
  st_e              st_q;
  logic [2:0]       fcnt_q;
  logic [1:0]       fa_q, fb_q, fa_d, fb_d;
  logic [CNT_W-1:0] sc_q, fc_q;

  logic m1_ex, m1_mem, m1_wb;
  logic m2_ex, m2_mem, m2_wb;
  logic hazard, redirect, flushing;
  logic stall, bubble, flush;

  assign m1_ex  = hs.id_use_rs1 && match(ex_q,  hs.id_rs1);
  assign m1_mem = hs.id_use_rs1 && match(mem_q, hs.id_rs1);
  assign m1_wb  = hs.id_use_rs1 && match(wb_q,  hs.id_rs1);
  assign m2_ex  = hs.id_use_rs2 && match(ex_q,  hs.id_rs2);
  assign m2_mem = hs.id_use_rs2 && match(mem_q, hs.id_rs2);
  assign m2_wb  = hs.id_use_rs2 && match(wb_q,  hs.id_rs2);

  // With forwarding only a load still in EX cannot supply its result in time.
  assign hazard = FORWARDING
    ? (ex_ld_q && (m1_ex || m2_ex))
    : (m1_ex || m1_mem || m1_wb ||
       m2_ex || m2_mem || m2_wb);

  assign redirect = hs.ex_redirect;
  assign flushing = (st_q == FLUSH) && (fcnt_q != 3'd0);
  assign stall    = hazard && !redirect && (st_q != FLUSH);
  assign flush    = redirect || flushing;
  assign bubble   = flush || stall;

  assign hs.pc_stall    = stall;
  assign hs.ifid_stall  = stall;
  assign hs.idex_bubble = bubble;
  assign hs.ifid_flush  = flush;
  assign hs.fwd_a       = fa_q;
  assign hs.fwd_b       = fb_q;
  assign hs.state       = st_q;
  assign hs.stall_cnt   = sc_q;
  assign hs.flush_cnt   = fc_q;

  always_comb begin
    ex_d    = '0;
    ex_ld_d = 1'b0;
    fa_d    = 2'b00;
    fb_d    = 2'b00;
    if (hs.id_valid && !bubble) begin
      ex_d.v  = hs.id_reg_en && (hs.id_rd != 5'd0);
      ex_d.rd = hs.id_rd;
      ex_ld_d = hs.id_is_load;
    end
    if (FORWARDING && !bubble) begin
      fa_d = m1_ex ? 2'b01 : m1_mem ? 2'b10 : 2'b00;
      fb_d = m2_ex ? 2'b01 : m2_mem ? 2'b10 : 2'b00;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      ex_ld_q <= 1'b0;
      fa_q    <= 2'b00;
      fb_q    <= 2'b00;
    end else begin
      wb_q    <= mem_q;
      mem_q   <= ex_q;
      ex_q    <= ex_d;
      ex_ld_q <= ex_ld_d;
      fa_q    <= fa_d;
      fb_q    <= fb_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      st_q   <= RUN;
      fcnt_q <= 3'd0;
    end else if (redirect) begin
      fcnt_q <= FLOAD;
      st_q   <= (FLOAD != 3'd0) ? FLUSH : RUN;
    end else if (st_q == FLUSH) begin
      fcnt_q <= (fcnt_q != 3'd0) ? fcnt_q - 3'd1 : 3'd0;
      st_q   <= (fcnt_q > 3'd1) ? FLUSH : RUN;
    end else begin
      fcnt_q <= 3'd0;
      st_q   <= hazard ? STALL : RUN;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sc_q <= '0;
      fc_q <= '0;
    end else begin
      if (stall && (sc_q != '1))
        sc_q <= sc_q + 1'b1;
      if (flush && (fc_q != '1))
        fc_q <= fc_q + 1'b1;
    end
  end

endmodule
